zap_fetch_main: RTL and testbench

- Fetch stage directly upstream of the predecode stage.
- Registers the instruction word returned by instruction memory, together with its PC, PC+8 and abort status.
- Attaches a 2-bit branch prediction state read from an internal branch history table (BHT).
- Updates the BHT from ALU-resolved branch outcomes and sweeps it to a known state after reset.

---
 rtl/zap_fetch_main_pkg.sv | 26 ++
 rtl/zap_branch_predict_ram.sv | 60 ++++++
 rtl/zap_fetch_main.sv | 94 +++++++++
 tb/tb_zap_fetch_main.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_fetch_main_pkg.sv
// Shared definitions for the fetch stage and its branch history table.
// The prediction encoding is also used by predecode, so it lives here.
package zap_fetch_main_pkg;

   // 2-bit saturating branch prediction states.
   localparam logic [1:0] SNT = 2'd0;
   localparam logic [1:0] WNT = 2'd1;
   localparam logic [1:0] WT  = 2'd2;
   localparam logic [1:0] ST  = 2'd3;

   // BHT sweep FSM states.
   localparam logic [0:0] BP_INIT = 1'b0;
   localparam logic [0:0] BP_RUN  = 1'b1;

   // Saturating counter step: taken moves toward ST, not taken toward SNT.
   function automatic logic [1:0] bp_sat_update(input logic [1:0] cur, input logic taken);
      logic [1:0] nxt;
      if (taken) begin
         nxt = (cur == ST) ? ST : cur + 2'd1;
      end else begin
         nxt = (cur == SNT) ? SNT : cur - 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/zap_branch_predict_ram.sv
// Branch history table: 2-bit counters, one update port with write-through
// bypass to the read port, and a post-reset sweep that sets every entry to WNT.
module zap_branch_predict_ram
   import zap_fetch_main_pkg::*;
#(
   parameter int unsigned BP_ENTRIES = 1024,
   parameter int unsigned BP_IDX_W   = 10
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [BP_IDX_W-1:0] i_rd_idx,
   output logic [1:0]          o_rd_state,
   input  logic                i_upd_valid,
   input  logic [BP_IDX_W-1:0] i_upd_idx,
   input  logic                i_upd_taken,
   output logic                o_busy
);

   localparam logic [BP_IDX_W-1:0] LAST_IDX = BP_IDX_W'(BP_ENTRIES - 1);

   logic [1:0]          bht [BP_ENTRIES];
   logic [0:0]          state;
   logic [BP_IDX_W-1:0] sweep_idx;
   logic                upd_en;
   logic [1:0]          upd_state;

   // Update is only honoured once the sweep has finished; read bypasses a
   // same-index update so the fetch sees the post-update counter.
   always_comb begin
      upd_en     = i_upd_valid && (state == BP_RUN);
      upd_state  = bp_sat_update(bht[i_upd_idx], i_upd_taken);
      o_rd_state = (upd_en && (i_upd_idx == i_rd_idx)) ? upd_state : bht[i_rd_idx];
      o_busy     = (state == BP_INIT);
   end

   // Sweep FSM: walk every index once after reset, then run.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state     <= BP_INIT;
         sweep_idx <= '0;
      end else if (state == BP_INIT) begin
         sweep_idx <= sweep_idx + 1'b1;
         if (sweep_idx == LAST_IDX) begin
            state <= BP_RUN;
         end
      end
   end

   // Single write port shared between the sweep and branch updates.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         if (state == BP_INIT) begin
            bht[sweep_idx] <= WNT;
         end else if (upd_en) begin
            bht[i_upd_idx] <= upd_state;
         end
      end
   end

endmodule

// File: rtl/zap_fetch_main.sv
// Fetch stage: registers the memory word with its PC, PC+8, abort status and
// BHT prediction, under a clear/stall priority chain from downstream stages.
module zap_fetch_main
   import zap_fetch_main_pkg::*;
#(
   parameter int unsigned BP_ENTRIES = 1024,
   parameter int unsigned BP_IDX_W   = $clog2(BP_ENTRIES)
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_clear_from_writeback,
   input  logic        i_data_stall,
   input  logic        i_clear_from_alu,
   input  logic        i_stall_from_shifter,
   input  logic        i_stall_from_issue,
   input  logic        i_stall_from_decode,
   input  logic        i_clear_from_decode,
   input  logic [31:0] i_pc_ff,
   input  logic [31:0] i_instruction,
   input  logic        i_valid,
   input  logic        i_instr_abort,
   input  logic        i_bp_update_valid,
   input  logic [31:0] i_bp_update_pc,
   input  logic        i_bp_update_taken,
   output logic [31:0] o_instruction,
   output logic        o_valid,
   output logic        o_instr_abort,
   output logic [31:0] o_pc_ff,
   output logic [31:0] o_pc_plus_8_ff,
   output logic [1:0]  o_taken_ff,
   output logic        o_bp_init_busy
);

   logic [1:0] bp_rd_state;
   logic       bp_busy;

   // Word-aligned PC bits index the table; the rest alias by design.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{i_pc_ff[1:0], i_bp_update_pc[1:0],
                             i_pc_ff[31:BP_IDX_W+2], i_bp_update_pc[31:BP_IDX_W+2]};

   zap_branch_predict_ram #(
      .BP_ENTRIES (BP_ENTRIES),
      .BP_IDX_W   (BP_IDX_W)
   ) u_bp_ram (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_rd_idx    (i_pc_ff[BP_IDX_W+1:2]),
      .o_rd_state  (bp_rd_state),
      .i_upd_valid (i_bp_update_valid),
      .i_upd_idx   (i_bp_update_pc[BP_IDX_W+1:2]),
      .i_upd_taken (i_bp_update_taken),
      .o_busy      (bp_busy)
   );

   assign o_bp_init_busy = bp_busy;

   // Output register with clear/stall priority; a stall wins over a decode
   // clear so predecode re-evaluates the held branch.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_instruction  <= '0;
         o_valid        <= 1'b0;
         o_instr_abort  <= 1'b0;
         o_pc_ff        <= '0;
         o_pc_plus_8_ff <= '0;
         o_taken_ff     <= SNT;
      end else if (bp_busy || i_clear_from_writeback) begin
         o_valid       <= 1'b0;
         o_instr_abort <= 1'b0;
         o_taken_ff    <= SNT;
      end else if (i_data_stall) begin
         // hold
      end else if (i_clear_from_alu) begin
         o_valid       <= 1'b0;
         o_instr_abort <= 1'b0;
         o_taken_ff    <= SNT;
      end else if (i_stall_from_shifter || i_stall_from_issue || i_stall_from_decode) begin
         // hold
      end else if (i_clear_from_decode) begin
         o_valid       <= 1'b0;
         o_instr_abort <= 1'b0;
         o_taken_ff    <= SNT;
      end else begin
         o_instruction  <= i_instruction;
         o_valid        <= i_valid;
         o_instr_abort  <= i_instr_abort & i_valid;
         o_pc_ff        <= i_pc_ff;
         o_pc_plus_8_ff <= i_pc_ff + 32'd8;
         o_taken_ff     <= bp_rd_state;
      end
   end

endmodule

// File: tb/tb_zap_fetch_main.sv
// Bench for zap_fetch_main: sweep timing, a directed vector table, reset during
// the sweep and randomized traffic against a behavioural model.
module tb_zap_fetch_main;

   // ctl bit order: {wb, ds, alu, sh, is, sd, cd}
   localparam logic [6:0] WB  = 7'b1000000;
   localparam logic [6:0] DS  = 7'b0100000;
   localparam logic [6:0] ALU = 7'b0010000;
   localparam logic [6:0] SH  = 7'b0001000;
   localparam logic [6:0] IS  = 7'b0000100;
   localparam logic [6:0] SD  = 7'b0000010;
   localparam logic [6:0] CD  = 7'b0000001;

   typedef struct {
      logic [6:0]  ctl;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        valid;
      logic        abort;
      logic        uv;
      logic [31:0] upc;
      logic        ut;
   } in_t;

   typedef struct {
      in_t         in;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic        e_valid;
      logic        e_abort;
      logic [1:0]  e_taken;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr_wb, dstall, clr_alu, st_sh, st_is, st_dec, clr_dec;
   logic [31:0] pc_in, instr_in, upd_pc;
   logic        valid_in, abort_in, upd_v, upd_t;
   logic [31:0] instr_out, pc_out, pc8_out;
   logic        valid_out, abort_out, busy;
   logic [1:0]  taken_out;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   int unsigned m_bht [1024];
   logic [31:0] m_pc, m_pc8, m_instr;
   logic        m_valid, m_abort;
   logic [1:0]  m_taken;
   bit          model_run = 0;

   vec_t vecs[$];

   always #5 clk = ~clk;

   zap_fetch_main dut (
      .i_clk                  (clk),
      .i_reset                (rst),
      .i_clear_from_writeback (clr_wb),
      .i_data_stall           (dstall),
      .i_clear_from_alu       (clr_alu),
      .i_stall_from_shifter   (st_sh),
      .i_stall_from_issue     (st_is),
      .i_stall_from_decode    (st_dec),
      .i_clear_from_decode    (clr_dec),
      .i_pc_ff                (pc_in),
      .i_instruction          (instr_in),
      .i_valid                (valid_in),
      .i_instr_abort          (abort_in),
      .i_bp_update_valid      (upd_v),
      .i_bp_update_pc         (upd_pc),
      .i_bp_update_taken      (upd_t),
      .o_instruction          (instr_out),
      .o_valid                (valid_out),
      .o_instr_abort          (abort_out),
      .o_pc_ff                (pc_out),
      .o_pc_plus_8_ff         (pc8_out),
      .o_taken_ff             (taken_out),
      .o_bp_init_busy         (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic in_t mkin(logic [6:0] ctl, logic [31:0] pc, logic [31:0] instr,
                                logic valid, logic abort, logic uv, logic [31:0] upc,
                                logic ut);
      in_t r;
      r.ctl = ctl; r.pc = pc; r.instr = instr; r.valid = valid; r.abort = abort;
      r.uv = uv; r.upc = upc; r.ut = ut;
      return r;
   endfunction

   task automatic add(in_t in, logic [31:0] e_pc, logic [31:0] e_instr, logic e_valid,
                      logic e_abort, logic [1:0] e_taken);
      vec_t v;
      v.in = in; v.e_pc = e_pc; v.e_instr = e_instr; v.e_valid = e_valid;
      v.e_abort = e_abort; v.e_taken = e_taken;
      vecs.push_back(v);
   endtask

   // Post-sweep model state: every counter WNT, output register cleared.
   task automatic model_reset();
      for (int i = 0; i < 1024; i++) m_bht[i] = 1;
      m_pc = 0; m_pc8 = 0; m_instr = 0; m_valid = 0; m_abort = 0; m_taken = 0;
   endtask

   // One cycle of the fetch stage as described by its rules.
   task automatic model_step(in_t in);
      int unsigned k;
      int unsigned rd;
      if (in.uv) begin
         k = in.upc[11:2];
         if (in.ut) m_bht[k] = (m_bht[k] == 3) ? 3 : m_bht[k] + 1;
         else       m_bht[k] = (m_bht[k] == 0) ? 0 : m_bht[k] - 1;
      end
      rd = m_bht[in.pc[11:2]];
      if (in.ctl[6] || (!in.ctl[5] && in.ctl[4]) ||
          (!in.ctl[5] && !in.ctl[4] && in.ctl[3:1] == 3'b000 && in.ctl[0])) begin
         m_valid = 0; m_abort = 0; m_taken = 0;
      end else if (in.ctl == 7'b0) begin
         m_instr = in.instr; m_valid = in.valid; m_abort = in.abort & in.valid;
         m_pc = in.pc; m_pc8 = in.pc + 32'd8; m_taken = 2'(rd);
      end
   endtask

   task automatic drive_cycle(in_t in);
      {clr_wb, dstall, clr_alu, st_sh, st_is, st_dec, clr_dec} = in.ctl;
      pc_in = in.pc; instr_in = in.instr; valid_in = in.valid; abort_in = in.abort;
      upd_v = in.uv; upd_pc = in.upc; upd_t = in.ut;
      if (model_run) model_step(in);
      tick();
   endtask

   // Count busy cycles after reset release; valid must stay low meanwhile.
   task automatic measure_sweep(string tag);
      int n = 0;
      valid_in = 1; upd_v = 1; upd_pc = 32'h100; upd_t = 1; pc_in = 32'h100;
      while (busy === 1'b1 && n < 2000) begin
         if (valid_out !== 1'b0) chk({tag, "_init_valid"}, valid_out, 0);
         n++;
         tick();
      end
      chk({tag, "_busy_len"}, n, 1024);
      chk({tag, "_busy_after"}, busy, 0);
      upd_v = 0;
   endtask

   task automatic check_model(string tag);
      chk({tag, "_pc"}, pc_out, m_pc);
      chk({tag, "_pc8"}, pc8_out, m_pc8);
      chk({tag, "_instr"}, instr_out, m_instr);
      chk({tag, "_valid"}, valid_out, 32'(m_valid));
      chk({tag, "_abort"}, abort_out, 32'(m_abort));
      chk({tag, "_taken"}, taken_out, 32'(m_taken));
   endtask

   initial begin
      rst = 1;
      {clr_wb, dstall, clr_alu, st_sh, st_is, st_dec, clr_dec} = 7'b0;
      pc_in = 32'h100; instr_in = 32'hDEADBEEF; valid_in = 1; abort_in = 1;
      upd_v = 0; upd_pc = 0; upd_t = 0;
      tick(); tick();

      chk("rst_valid", valid_out, 0);
      chk("rst_abort", abort_out, 0);
      chk("rst_taken", taken_out, 0);
      chk("rst_instr", instr_out, 0);
      chk("rst_pc", pc_out, 0);
      chk("rst_pc8", pc8_out, 0);
      chk("rst_busy", busy, 1);

      rst = 0;
      abort_in = 0;
      measure_sweep("sweep1");
      model_reset();
      model_run = 1;

      // Directed vectors
      add(mkin(0, 32'h100, 32'hEA000004, 1, 0, 0, 0, 0), 32'h100, 32'hEA000004, 1, 0, 1);
      add(mkin(0, 32'hFFFFFFFC, 32'h11111111, 1, 0, 0, 0, 0),
          32'hFFFFFFFC, 32'h11111111, 1, 0, 1);
      add(mkin(0, 32'h104, 32'h22, 1, 0, 1, 32'h200, 1), 32'h104, 32'h22, 1, 0, 1);
      add(mkin(0, 32'h108, 32'h33, 1, 0, 1, 32'h200, 1), 32'h108, 32'h33, 1, 0, 1);
      add(mkin(0, 32'h10C, 32'h44, 1, 0, 1, 32'h200, 1), 32'h10C, 32'h44, 1, 0, 1);
      add(mkin(0, 32'h200, 32'hA0, 1, 0, 0, 0, 0), 32'h200, 32'hA0, 1, 0, 3);
      add(mkin(0, 32'h204, 32'hA1, 1, 0, 1, 32'h200, 1), 32'h204, 32'hA1, 1, 0, 1);
      add(mkin(0, 32'h200, 32'hA2, 1, 0, 0, 0, 0), 32'h200, 32'hA2, 1, 0, 3);
      add(mkin(0, 32'h200, 32'hB0, 1, 0, 1, 32'h200, 0), 32'h200, 32'hB0, 1, 0, 2);
      add(mkin(0, 32'h200, 32'hB1, 1, 0, 1, 32'h200, 0), 32'h200, 32'hB1, 1, 0, 1);
      add(mkin(0, 32'h200, 32'hB2, 1, 0, 1, 32'h200, 0), 32'h200, 32'hB2, 1, 0, 0);
      add(mkin(0, 32'h200, 32'hB3, 1, 0, 1, 32'h200, 0), 32'h200, 32'hB3, 1, 0, 0);
      add(mkin(0, 32'h200, 32'hB4, 1, 0, 1, 32'h200, 0), 32'h200, 32'hB4, 1, 0, 0);
      add(mkin(0, 32'h300, 32'hC0, 1, 0, 1, 32'h300, 1), 32'h300, 32'hC0, 1, 0, 2);
      add(mkin(0, 32'h304, 32'h4444, 1, 0, 0, 0, 0), 32'h304, 32'h4444, 1, 0, 1);
      add(mkin(SD | CD, 32'h500, 32'h55, 1, 0, 0, 0, 0), 32'h304, 32'h4444, 1, 0, 1);
      add(mkin(DS | ALU, 32'h500, 32'h55, 1, 0, 0, 0, 0), 32'h304, 32'h4444, 1, 0, 1);
      add(mkin(WB | DS, 32'h500, 32'h55, 1, 0, 0, 0, 0), 32'h304, 32'h4444, 0, 0, 0);
      add(mkin(0, 32'h308, 32'h66, 1, 1, 0, 0, 0), 32'h308, 32'h66, 1, 1, 1);
      add(mkin(ALU, 32'h500, 32'h55, 1, 0, 0, 0, 0), 32'h308, 32'h66, 0, 0, 0);
      add(mkin(0, 32'h30C, 32'h77, 0, 1, 0, 0, 0), 32'h30C, 32'h77, 0, 0, 1);
      add(mkin(SH, 32'h500, 32'h55, 1, 1, 1, 32'h200, 1), 32'h30C, 32'h77, 0, 0, 1);
      add(mkin(IS, 32'h500, 32'h55, 1, 1, 0, 0, 0), 32'h30C, 32'h77, 0, 0, 1);
      add(mkin(0, 32'h310, 32'h88, 1, 0, 0, 0, 0), 32'h310, 32'h88, 1, 0, 1);
      add(mkin(CD, 32'h500, 32'h55, 1, 0, 0, 0, 0), 32'h310, 32'h88, 0, 0, 0);
      add(mkin(0, 32'h200, 32'h99, 1, 0, 0, 0, 0), 32'h200, 32'h99, 1, 0, 1);

      foreach (vecs[i]) begin
         drive_cycle(vecs[i].in);
         chk($sformatf("vec%0d_pc", i), pc_out, vecs[i].e_pc);
         chk($sformatf("vec%0d_pc8", i), pc8_out, vecs[i].e_pc + 32'd8);
         chk($sformatf("vec%0d_instr", i), instr_out, vecs[i].e_instr);
         chk($sformatf("vec%0d_valid", i), valid_out, 32'(vecs[i].e_valid));
         chk($sformatf("vec%0d_abort", i), abort_out, 32'(vecs[i].e_abort));
         chk($sformatf("vec%0d_taken", i), taken_out, 32'(vecs[i].e_taken));
      end
      chk("wrap_pc8_explicit", 32'hFFFFFFFC + 32'd8, 32'h4);

      // Randomized traffic over a small index window so updates and fetches collide.
      for (int i = 0; i < 400; i++) begin
         in_t r;
         r.ctl = 7'b0;
         for (int b = 0; b < 7; b++) r.ctl[b] = ($urandom_range(0, 9) == 0);
         r.pc    = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 7)) << 2) | ($urandom & 3);
         r.instr = $urandom;
         r.valid = $urandom_range(0, 3) != 0;
         r.abort = $urandom_range(0, 3) == 0;
         r.uv    = $urandom_range(0, 1) == 1;
         r.upc   = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 7)) << 2);
         r.ut    = $urandom_range(0, 1) == 1;
         drive_cycle(r);
         check_model($sformatf("rnd%0d", i));
      end

      // Reset partway through the sweep restarts it from index 0.
      model_run = 0;
      {clr_wb, dstall, clr_alu, st_sh, st_is, st_dec, clr_dec} = 7'b0;
      rst = 1; tick(); rst = 0;
      upd_v = 1; upd_pc = 32'h300; upd_t = 1; valid_in = 1;
      repeat (500) tick();
      chk("mid_busy", busy, 1);
      chk("mid_valid", valid_out, 0);
      rst = 1; tick(); rst = 0;
      measure_sweep("sweep2");
      model_reset();
      model_run = 1;
      drive_cycle(mkin(0, 32'h200, 32'h1234, 1, 0, 0, 0, 0));
      chk("post_rst_0x200_taken", taken_out, 1);
      check_model("post_rst_a");
      drive_cycle(mkin(0, 32'h300, 32'h5678, 1, 0, 0, 0, 0));
      chk("post_rst_0x300_taken", taken_out, 1);
      check_model("post_rst_b");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
